// File: rtl/decode_stage.sv
// decode_stage: RV32I decode between the IF/ID handshake and the ID/EX register.
// Drives register-file read indices straight from the offered instruction,
// forwards a same-cycle writeback, builds immediates, stalls on load-use and
// registers the decoded fields toward execute with a valid/ready handshake.
module decode_stage #(
   parameter bit BYPASS_EN      = 1'b1,
   parameter bit LOAD_USE_STALL = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic [31:0] if_instr,
   input  logic [31:0] if_pc,
   input  logic        flush,
   output logic [4:0]  rf_r1_idx,
   output logic [4:0]  rf_r2_idx,
   input  logic [31:0] rf_r1_data,
   input  logic [31:0] rf_r2_data,
   input  logic        wb_we,
   input  logic [4:0]  wb_idx,
   input  logic [31:0] wb_data,
   output logic        ex_valid,
   input  logic        ex_ready,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_rs1_val,
   output logic [31:0] ex_rs2_val,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rd,
   output logic [6:0]  ex_opcode,
   output logic [2:0]  ex_funct3,
   output logic [6:0]  ex_funct7,
   output logic        ex_is_load,
   output logic        ex_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   logic [6:0]  opc;
   logic [4:0]  rs1, rs2;
   logic        legal, use_rs1, use_rs2, has_rd;
   logic [31:0] imm;
   logic [31:0] op1, op2;
   logic        hz, accept;

   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d, rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d, imm_q, imm_d;
   logic [4:0]  rd_q, rd_d;
   logic [6:0]  opcode_q, opcode_d, funct7_q, funct7_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        is_load_q, is_load_d, illegal_q, illegal_d;

   assign opc       = if_instr[6:0];
   assign rs1       = if_instr[19:15];
   assign rs2       = if_instr[24:20];
   assign rf_r1_idx = rs1;
   assign rf_r2_idx = rs2;

   // Format decode: legality, which sources are read, rd presence, immediate
   always_comb begin
      legal   = 1'b1;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      has_rd  = 1'b1;
      imm     = '0;
      case (opc)
         OPC_LUI, OPC_AUIPC: imm = {if_instr[31:12], 12'b0};
         OPC_JAL: imm = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20],
                         if_instr[30:21], 1'b0};
         OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
            use_rs1 = 1'b1;
            imm     = {{20{if_instr[31]}}, if_instr[31:20]};
         end
         // FENCE/SYSTEM carry an I-type field but read no operand for hazards
         OPC_FENCE, OPC_SYSTEM: imm = {{20{if_instr[31]}}, if_instr[31:20]};
         OPC_BRANCH: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            has_rd  = 1'b0;
            imm     = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25],
                       if_instr[11:8], 1'b0};
         end
         OPC_STORE: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            has_rd  = 1'b0;
            imm     = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
         end
         OPC_OP: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         default: begin
            legal  = 1'b0;
            has_rd = 1'b0;
         end
      endcase
   end

   // Operand select: x0 is hard zero, then writeback forward, then register file
   always_comb begin
      op1 = rf_r1_data;
      op2 = rf_r2_data;
      if (rs1 == 5'd0)
         op1 = '0;
      else if (BYPASS_EN && wb_we && wb_idx == rs1)
         op1 = wb_data;
      if (rs2 == 5'd0)
         op2 = '0;
      else if (BYPASS_EN && wb_we && wb_idx == rs2)
         op2 = wb_data;
   end

   // Load-use hazard against the instruction held in ID/EX
   assign hz = LOAD_USE_STALL && valid_q && is_load_q && (rd_q != 5'd0) &&
               ((use_rs1 && rs1 == rd_q) || (use_rs2 && rs2 == rd_q));

   assign if_ready = rst_n & ~flush & ~hz & (~valid_q | ex_ready);
   assign accept   = if_valid & if_ready;

   // ID/EX next state: flush beats accept beats drain; otherwise hold
   always_comb begin
      valid_d   = valid_q;
      pc_d      = pc_q;
      rs1_val_d = rs1_val_q;
      rs2_val_d = rs2_val_q;
      imm_d     = imm_q;
      rd_d      = rd_q;
      opcode_d  = opcode_q;
      funct3_d  = funct3_q;
      funct7_d  = funct7_q;
      is_load_d = is_load_q;
      illegal_d = illegal_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d   = 1'b1;
         pc_d      = if_pc;
         rs1_val_d = op1;
         rs2_val_d = op2;
         imm_d     = imm;
         rd_d      = has_rd ? if_instr[11:7] : 5'd0;
         opcode_d  = opc;
         funct3_d  = if_instr[14:12];
         funct7_d  = if_instr[31:25];
         is_load_d = (opc == OPC_LOAD);
         illegal_d = ~legal;
      end else if (ex_ready) begin
         valid_d = 1'b0;
      end
   end

   // ID/EX pipeline register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         rs1_val_q <= '0;
         rs2_val_q <= '0;
         imm_q     <= '0;
         rd_q      <= '0;
         opcode_q  <= '0;
         funct3_q  <= '0;
         funct7_q  <= '0;
         is_load_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         rs1_val_q <= rs1_val_d;
         rs2_val_q <= rs2_val_d;
         imm_q     <= imm_d;
         rd_q      <= rd_d;
         opcode_q  <= opcode_d;
         funct3_q  <= funct3_d;
         funct7_q  <= funct7_d;
         is_load_q <= is_load_d;
         illegal_q <= illegal_d;
      end
   end

   assign ex_valid   = valid_q;
   assign ex_pc      = pc_q;
   assign ex_rs1_val = rs1_val_q;
   assign ex_rs2_val = rs2_val_q;
   assign ex_imm     = imm_q;
   assign ex_rd      = rd_q;
   assign ex_opcode  = opcode_q;
   assign ex_funct3  = funct3_q;
   assign ex_funct7  = funct7_q;
   assign ex_is_load = is_load_q;
   assign ex_illegal = illegal_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
IF/ID-to-ID/EX decode stage for the RV32I pipeline. It accepts fetched instructions over a valid/ready handshake and drives the register file read indices combinationally from the incoming instruction. It bypasses the same-cycle writeback value, generates immediates, detects load-use hazards, and registers everything into the ID/EX pipeline register with valid/ready toward execute.

Parameters:
BYPASS_EN, 1, 1 = forward wb_data onto an operand when wb_idx matches that source index; 0 = always use the register file value
LOAD_USE_STALL, 1, 1 = insert a one-cycle bubble on load-use hazard; 0 = never stall for it

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  fetch offers an instruction
if_ready  out  1  decode accepts this cycle
if_instr  in  32  instruction word
if_pc  in  32  instruction PC
flush  in  1  kill the held and the incoming instruction
rf_r1_idx  out  5  register file read index 1 = if_instr[19:15]
rf_r2_idx  out  5  register file read index 2 = if_instr[24:20]
rf_r1_data  in  32  register file read data 1 (combinational)
rf_r2_data  in  32  register file read data 2 (combinational)
wb_we  in  1  writeback write enable (same signals as the register file write port)
wb_idx  in  5  writeback register index
wb_data  in  32  writeback data
ex_valid  out  1  ID/EX register holds a valid instruction
ex_ready  in  1  execute accepts
ex_pc  out  32  registered PC
ex_rs1_val  out  32  operand 1
ex_rs2_val  out  32  operand 2
ex_imm  out  32  sign-extended immediate
ex_rd  out  5  destination index; 0 when there is no writeback
ex_opcode  out  7  instr[6:0]
ex_funct3  out  3  instr[14:12]
ex_funct7  out  7  instr[31:25]
ex_is_load  out  1  opcode 0000011
ex_illegal  out  1  opcode not in the RV32I set

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs are 0. if_ready is 0 while in reset and 1 after release when flush=0.
- Hazard: hz = LOAD_USE_STALL & ex_valid & ex_is_load & ex_rd!=0 & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd)).
- Source usage by format:
  - use_rs1 for R, I (OP-IMM, LOAD, JALR), S, B.
  - use_rs2 for R, S, B.
- if_ready = ~flush & ~hz & (~ex_valid | ex_ready). Accept = if_valid & if_ready.
- Register update priority at each clock edge:
  - flush: ex_valid<=0.
  - else accept: load all ex_* fields, ex_valid<=1.
  - else ex_ready: ex_valid<=0 (bubble; this covers a hazard stall).
  - else hold all fields.
- Latency: one cycle from accept to ex_valid. No skid buffer. Throughput is 1 instruction/cycle when ex_ready=1.
- Operand select (per source, evaluated in the accept cycle), in priority order:
  - index==0 -> 0.
  - BYPASS_EN & wb_we & wb_idx==index -> wb_data.
  - otherwise rf_rN_data.
- Immediates (all sign-extended from instr[31]):
  - I: instr[31:20].
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - U: {instr[31:12],12'b0}.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - Formats with no immediate (R, illegal) -> 0.
- Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011. Any other opcode -> ex_illegal=1, ex_rd=0, ex_imm=0.
- ex_rd is forced to 0 for S and B formats.
- Boundaries:
  - Flush during stall or hazard: ex_valid<=0 and nothing is accepted.
  - A load with rd=x0 never stalls.
  - While ex_ready=0: outputs stay bit-stable.
  - Reset asserted mid-transfer: outputs drop to 0 immediately.

Test Plan:
- Reset: hold valid state, pulse rst_n=0 asynchronously mid-cycle -> ex_valid=0 and all ex_* =0 immediately; if_ready=1 after release.
- Basic decode: if_instr=0xFFF08293 (addi x5,x1,-1), rf_r1_data=0xDEADBEEF, ex_ready=1 -> next cycle ex_valid=1, ex_rs1_val=0xDEADBEEF, ex_imm=0xFFFFFFFF, ex_rd=5, ex_opcode=0010011.
- Bypass: 0x002081B3 (add x3,x1,x2) with rf_r2_data=0xCAFEBABE, wb_we=1, wb_idx=2, wb_data=0xDEADC0DE -> ex_rs2_val=0xDEADC0DE. Repeat with BYPASS_EN=0 -> 0xCAFEBABE. Repeat with wb_idx=0 and rs=0 -> 0.
- Load-use: accept 0x0000A303 (lw x6,0(x1)), then offer 0x000303B3 (add x7,x6,x0) with ex_ready=1 -> if_ready=0 for one cycle, then a one-cycle ex_valid=0 bubble, then the add is accepted with ex_rd=7.
- Backpressure/flush: ex_ready=0 for 2 cycles -> outputs stable, if_ready=0. Assert flush in the 2nd cycle -> ex_valid=0 next cycle and the offered instruction is not consumed.
- Immediate/illegal: 0xFE208EE3 (beq x1,x2,-4) -> ex_imm=0xFFFFFFFC, ex_rd=0. 0xFFFFFFFF -> ex_illegal=1, ex_rd=0, ex_imm=0.
